// File: rtl/cobra_bus_pkg.sv
// Shared types and helpers for the Cobra1 bus responder and related bus masters.
// Holds the machine-cycle decode used by z80_bus_responder.
package cobra_bus_pkg;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    OPFETCH = 3'd1,
    MEM_RD  = 3'd2,
    MEM_WR  = 3'd3,
    IO_RD   = 3'd4,
    IO_WR   = 3'd5,
    INTACK  = 3'd6
  } cycle_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } resp_state_t;

  localparam logic [7:0] DEFAULT_INT_VECTOR = 8'hFF;
  localparam logic [7:0] DEFAULT_OPEN_BUS   = 8'hFF;

  // Interrupt acknowledge wins over everything; a no-read, no-write cycle is idle.
  function automatic cycle_t decode_cycle(
    input logic m1_n,
    input logic iorq,
    input logic no_read,
    input logic write,
    input logic intcycle_n
  );
    cycle_t c;
    if (!intcycle_n) begin
      c = INTACK;
    end else if (no_read && !write) begin
      c = NONE;
    end else if (!m1_n) begin
      c = OPFETCH;
    end else if (iorq) begin
      c = write ? IO_WR : IO_RD;
    end else begin
      c = write ? MEM_WR : MEM_RD;
    end
    return c;
  endfunction

  function automatic logic needs_request(input cycle_t c);
    return (c != NONE) && (c != INTACK);
  endfunction

endpackage

// File: rtl/z80_cycle_timeout.sv
// Loadable down-counter that saturates at zero and flags expiry.
// Load takes priority over decrement.
module z80_cycle_timeout #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= {WIDTH{1'b0}};
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != {WIDTH{1'b0}})) begin
      count <= count - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign expired = (count == {WIDTH{1'b0}});

endmodule

// File: rtl/z80_bus_responder.sv
// Bridges tv80_core machine cycles onto a request/acknowledge memory/IO port,
// stretching the CPU with wait_n until the port answers or times out.
module z80_bus_responder
  import cobra_bus_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [7:0] INT_VECTOR     = DEFAULT_INT_VECTOR,
  parameter logic [7:0] OPEN_BUS       = DEFAULT_OPEN_BUS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m1_n,
  input  logic        iorq,
  input  logic        no_read,
  input  logic        write,
  input  logic        rfsh_n,
  input  logic        intcycle_n,
  input  logic [2:0]  ts,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic        wait_n,
  output logic [7:0]  di,
  output logic        xreq,
  output logic        xio,
  output logic        xwe,
  output logic [15:0] xaddr,
  output logic [7:0]  xwdata,
  input  logic        xack,
  input  logic [7:0]  xrdata,
  output logic        bus_err
);

  localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT_CYCLES - 1);

  resp_state_t state, state_next;
  cycle_t      cyc;
  logic        start;
  logic        tmr_load, tmr_en, tmr_expired;

  logic        wait_n_next, xreq_next, xio_next, xwe_next, bus_err_next;
  logic [7:0]  di_next, xwdata_next;
  logic [15:0] xaddr_next;

  z80_cycle_timeout #(.WIDTH(CW)) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (TO_LOAD),
    .enable     (tmr_en),
    .expired    (tmr_expired)
  );

  assign start = (ts == 3'd1) && rfsh_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-output logic; xwe doubles as the read/write memory of the cycle.
  always_comb begin
    state_next   = state;
    wait_n_next  = wait_n;
    di_next      = di;
    xreq_next    = xreq;
    xio_next     = xio;
    xwe_next     = xwe;
    xaddr_next   = xaddr;
    xwdata_next  = xwdata;
    bus_err_next = bus_err;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    cyc          = decode_cycle(m1_n, iorq, no_read, write, intcycle_n);
    case (state)
      IDLE: begin
        if (start) begin
          if (cyc == INTACK) begin
            di_next    = INT_VECTOR;
            state_next = DONE;
          end else if (!needs_request(cyc)) begin
            state_next = DONE;
          end else begin
            xaddr_next  = A;
            xwdata_next = dout;
            xio_next    = (cyc == IO_RD) || (cyc == IO_WR);
            xwe_next    = (cyc == MEM_WR) || (cyc == IO_WR);
            xreq_next   = 1'b1;
            wait_n_next = 1'b0;
            tmr_load    = 1'b1;
            state_next  = REQ;
          end
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (xack) begin
          xreq_next   = 1'b0;
          wait_n_next = 1'b1;
          if (!xwe) begin
            di_next = xrdata;
          end else begin
            di_next = di;
          end
          state_next = DONE;
        end else if (tmr_expired) begin
          xreq_next    = 1'b0;
          wait_n_next  = 1'b1;
          bus_err_next = 1'b1;
          if (!xwe) begin
            di_next = OPEN_BUS;
          end else begin
            di_next = di;
          end
          state_next = DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      DONE: begin
        if ((ts != 3'd1) && (ts != 3'd2) && (ts != 3'd3)) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next  = IDLE;
        xreq_next   = 1'b0;
        wait_n_next = 1'b1;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_n  <= 1'b1;
      di      <= 8'h00;
      xreq    <= 1'b0;
      xio     <= 1'b0;
      xwe     <= 1'b0;
      xaddr   <= 16'h0000;
      xwdata  <= 8'h00;
      bus_err <= 1'b0;
    end else begin
      wait_n  <= wait_n_next;
      di      <= di_next;
      xreq    <= xreq_next;
      xio     <= xio_next;
      xwe     <= xwe_next;
      xaddr   <= xaddr_next;
      xwdata  <= xwdata_next;
      bus_err <= bus_err_next;
    end
  end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Self-checking bench for z80_bus_responder: directed plan cases plus random
// machine cycles checked against a transaction-level model.
module tb_z80_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        m1_n, iorq, no_read, write, rfsh_n, intcycle_n;
  logic [2:0]  ts;
  logic [15:0] A;
  logic [7:0]  dout;
  logic        wait_n;
  logic [7:0]  di;
  logic        xreq, xio, xwe;
  logic [15:0] xaddr;
  logic [7:0]  xwdata;
  logic        xack;
  logic [7:0]  xrdata;
  logic        bus_err;

  int tests = 0;
  int fails = 0;

  // Transaction-level model state
  logic [7:0] m_di;
  logic       m_err;

  localparam int TMO = 16;

  z80_bus_responder dut (
    .clk(clk), .reset(reset), .m1_n(m1_n), .iorq(iorq), .no_read(no_read),
    .write(write), .rfsh_n(rfsh_n), .intcycle_n(intcycle_n), .ts(ts), .A(A),
    .dout(dout), .wait_n(wait_n), .di(di), .xreq(xreq), .xio(xio), .xwe(xwe),
    .xaddr(xaddr), .xwdata(xwdata), .xack(xack), .xrdata(xrdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 opfetch, 1 mem rd, 2 mem wr, 3 io rd, 4 io wr, 5 intack, 6 none
  // delay: clocks from request to xack; beyond TMO means no xack at all
  task automatic run_cycle(input int kind, input logic [15:0] a, input logic [7:0] d,
                           input int delay, input logic [7:0] rd);
    bit is_req, is_rd, acked, e_io, e_we;
    int end_k;
    is_req = (kind < 5);
    is_rd  = (kind == 0) || (kind == 1) || (kind == 3);
    e_io   = (kind == 3) || (kind == 4);
    e_we   = (kind == 2) || (kind == 4);
    acked  = (delay <= TMO);
    end_k  = acked ? delay : TMO;

    @(negedge clk);
    m1_n = (kind == 0) ? 1'b0 : 1'b1;
    iorq = e_io;
    write = e_we;
    no_read = (kind == 6);
    intcycle_n = (kind == 5) ? 1'b0 : 1'b1;
    rfsh_n = 1'b1;
    A = a;
    dout = d;
    ts = 3'd1;
    xack = 1'b0;

    if (is_req) begin
      for (int k = 0; k < end_k; k++) begin
        @(negedge clk);
        xack = 1'b0;
        ts = 3'd2;
        if (k > 0) A = 16'($urandom);
        check("xreq_wait", {31'd0, xreq}, 32'd1);
        check("wait_n_low", {31'd0, wait_n}, 32'd0);
        check("xaddr", {16'd0, xaddr}, {16'd0, a});
        if (k == 0) begin
          check("xwdata", {24'd0, xwdata}, {24'd0, d});
          check("xio", {31'd0, xio}, {31'd0, e_io});
          check("xwe", {31'd0, xwe}, {31'd0, e_we});
        end
        if (acked && (k == delay - 1)) begin
          xack = 1'b1;
          xrdata = rd;
        end
      end
      @(negedge clk);
      xack = 1'b0;
      if (acked) begin
        if (is_rd) m_di = rd;
      end else begin
        m_err = 1'b1;
        if (is_rd) m_di = 8'hFF;
      end
      check("xreq_drop", {31'd0, xreq}, 32'd0);
      check("wait_n_rel", {31'd0, wait_n}, 32'd1);
      check("di_end", {24'd0, di}, {24'd0, m_di});
      check("bus_err", {31'd0, bus_err}, {31'd0, m_err});
    end else begin
      @(negedge clk);
      ts = 3'd2;
      if (kind == 5) m_di = 8'hFF;
      check("noreq_xreq", {31'd0, xreq}, 32'd0);
      check("noreq_wait", {31'd0, wait_n}, 32'd1);
      check("noreq_di", {24'd0, di}, {24'd0, m_di});
    end

    // Still inside the machine cycle: ts==1 again and a stray xack must do nothing
    ts = 3'd1;
    m1_n = 1'b1; intcycle_n = 1'b1; no_read = 1'b0; iorq = 1'b0; write = 1'b0;
    xack = 1'b1;
    xrdata = 8'($urandom);
    @(negedge clk);
    xack = 1'b0;
    check("done_xreq", {31'd0, xreq}, 32'd0);
    check("done_di", {24'd0, di}, {24'd0, m_di});
    ts = 3'd4;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    m1_n = 1'b1; iorq = 1'b0; no_read = 1'b0; write = 1'b0; rfsh_n = 1'b1;
    intcycle_n = 1'b1; ts = 3'd4; A = 16'h0000; dout = 8'h00;
    xack = 1'b0; xrdata = 8'h00;
    m_di = 8'h00; m_err = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("rst_wait_n", {31'd0, wait_n}, 32'd1);
    check("rst_di", {24'd0, di}, 32'd0);
    check("rst_xreq", {31'd0, xreq}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_cycle(0, 16'h0000, 8'h00, 3, 8'h3E);
    run_cycle(2, 16'h8001, 8'hA5, 1, 8'h77);
    run_cycle(3, 16'h00FE, 8'h00, 2, 8'h1F);

    // Refresh with ts==1 must not start a cycle
    @(negedge clk);
    ts = 3'd1; rfsh_n = 1'b0; m1_n = 1'b0;
    @(negedge clk);
    check("rfsh_xreq", {31'd0, xreq}, 32'd0);
    check("rfsh_wait", {31'd0, wait_n}, 32'd1);
    ts = 3'd4; rfsh_n = 1'b1; m1_n = 1'b1;
    @(negedge clk);

    run_cycle(5, 16'h0038, 8'h00, 1, 8'h00);
    run_cycle(6, 16'h1234, 8'h00, 1, 8'h00);
    run_cycle(1, 16'h4000, 8'h00, 99, 8'h00);
    run_cycle(0, 16'h0001, 8'h00, 1, 8'hC3);
    run_cycle(1, 16'h4001, 8'h00, TMO, 8'h5A);

    // Reset while a request is outstanding
    @(negedge clk);
    A = 16'hBEEF; ts = 3'd1; m1_n = 1'b1; iorq = 1'b0; write = 1'b0;
    @(negedge clk);
    ts = 3'd2;
    check("pre_rst_xreq", {31'd0, xreq}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_xreq", {31'd0, xreq}, 32'd0);
    check("mid_rst_wait", {31'd0, wait_n}, 32'd1);
    check("mid_rst_di", {24'd0, di}, 32'd0);
    check("mid_rst_xaddr", {16'd0, xaddr}, 32'd0);
    check("mid_rst_xwdata", {24'd0, xwdata}, 32'd0);
    check("mid_rst_xio", {31'd0, xio}, 32'd0);
    check("mid_rst_xwe", {31'd0, xwe}, 32'd0);
    check("mid_rst_bus_err", {31'd0, bus_err}, 32'd0);
    xack = 1'b1; xrdata = 8'h55;
    @(negedge clk);
    xack = 1'b0;
    reset = 1'b0;
    ts = 3'd4;
    m_di = 8'h00; m_err = 1'b0;
    @(negedge clk);
    check("post_rst_xreq", {31'd0, xreq}, 32'd0);
    check("post_rst_di", {24'd0, di}, 32'd0);
    run_cycle(1, 16'h2000, 8'h00, 2, 8'h99);

    for (int n = 0; n < 30; n++) begin
      run_cycle(int'($urandom_range(0, 6)), 16'($urandom), 8'($urandom),
                int'($urandom_range(1, 20)), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
